// File: rtl/maxpool_window_gen.sv
// Streaming 5x5 window generator: turns one raster-order channel into 25-element
// window vectors for the combinational max-pool tree, with valid/ready on both sides.
module maxpool_window_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 20,
  parameter int IMG_H      = 20,
  parameter int K          = 5,
  parameter int STRIDE     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [K*K*DATA_WIDTH-1:0]    win_data,
  output logic                         win_valid,
  input  logic                         win_ready,
  output logic                         win_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = 3;
  localparam int WW = K * K * DATA_WIDTH;

  localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(K - 1 + ((IMG_W - K) / STRIDE) * STRIDE);
  localparam logic [RW-1:0] ROW_LAST  = RW'(K - 1 + ((IMG_H - K) / STRIDE) * STRIDE);
  localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [PW-1:0]         cph_q, cph_d;
  logic [PW-1:0]         rph_q, rph_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [WW-1:0]         data_q, data_d;
  logic [WW-1:0]         win_q, win_d;
  logic [K*DATA_WIDTH-1:0] col_vec;
  logic                  accept;
  logic                  emit;
  logic                  is_last;

  assign in_ready  = !valid_q || win_ready;
  assign accept    = in_valid && in_ready;
  assign win_valid = valid_q;
  assign win_last  = last_q;
  assign win_data  = data_q;

  // Buffer gi holds row r-4+gi; each accept moves the column up one buffer.
  generate
    for (genvar gi = 0; gi < K - 1; gi++) begin : g_line
      logic [DATA_WIDTH-1:0] mem [IMG_W];
      assign col_vec[gi*DATA_WIDTH +: DATA_WIDTH] = mem[col_q];
      always_ff @(posedge clk) begin
        if (accept) begin
          mem[col_q] <= col_vec[(gi+1)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  endgenerate
  assign col_vec[(K-1)*DATA_WIDTH +: DATA_WIDTH] = in_data;

  always_comb begin
    win_d = win_q;
    for (int wr = 0; wr < K; wr++) begin
      for (int wc = 0; wc < K - 1; wc++) begin
        win_d[DATA_WIDTH*(wr*K+wc) +: DATA_WIDTH] = win_q[DATA_WIDTH*(wr*K+wc+1) +: DATA_WIDTH];
      end
      win_d[DATA_WIDTH*(wr*K+K-1) +: DATA_WIDTH] = col_vec[DATA_WIDTH*wr +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      win_q <= win_d;
    end
  end

  // Phase counters track (idx-4) mod STRIDE so no divider is needed.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    cph_d = cph_q;
    rph_d = rph_q;
    if (accept) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        cph_d = '0;
        if (row_q == ROW_MAX) begin
          row_d = '0;
          rph_d = '0;
        end else begin
          row_d = row_q + RW'(1);
          rph_d = (row_q < ROW_FIRST || rph_q == PH_MAX) ? '0 : rph_q + PW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        cph_d = (col_q < COL_FIRST || cph_q == PH_MAX) ? '0 : cph_q + PW'(1);
      end
    end
  end

  assign emit = accept && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST) &&
                (rph_q == '0) && (cph_q == '0);
  assign is_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (emit) begin
      valid_d = 1'b1;
      last_d  = is_last;
      data_d  = win_d;
    end else if (win_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      cph_q   <= '0;
      rph_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      cph_q   <= cph_d;
      rph_q   <= rph_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: tb/tb_maxpool_window_gen.sv
// Bench for maxpool_window_gen: four instances with different geometry/stride,
// directed frames plus a random handshake run, checked against an indexing model.
module tb_maxpool_window_gen;
  localparam int DW = 16;
  localparam int WW = 400;

  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0] in_data   [4];
  logic          in_valid  [4];
  logic          in_ready  [4];
  logic [WW-1:0] win_data  [4];
  logic          win_valid [4];
  logic          win_ready [4];
  logic          win_last  [4];

  always #5 clk = ~clk;

  maxpool_window_gen #(.DATA_WIDTH(16), .IMG_W(5), .IMG_H(5), .K(5), .STRIDE(5)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .win_data(win_data[0]), .win_valid(win_valid[0]), .win_ready(win_ready[0]), .win_last(win_last[0]));
  maxpool_window_gen #(.DATA_WIDTH(16), .IMG_W(6), .IMG_H(6), .K(5), .STRIDE(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .win_data(win_data[1]), .win_valid(win_valid[1]), .win_ready(win_ready[1]), .win_last(win_last[1]));
  maxpool_window_gen #(.DATA_WIDTH(16), .IMG_W(10), .IMG_H(10), .K(5), .STRIDE(5)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .win_data(win_data[2]), .win_valid(win_valid[2]), .win_ready(win_ready[2]), .win_last(win_last[2]));
  maxpool_window_gen #(.DATA_WIDTH(16), .IMG_W(8), .IMG_H(8), .K(5), .STRIDE(1)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .win_data(win_data[3]), .win_valid(win_valid[3]), .win_ready(win_ready[3]), .win_last(win_last[3]));

  typedef struct {
    int            d;
    logic [WW-1:0] data;
    logic          last;
  } txn_t;

  typedef struct {
    int        widx;
    int        wr;
    int        wc;
    logic [15:0] exp_elem;
    logic      exp_last;
  } vec_t;

  txn_t        q[$];
  int          acc [4] = '{0, 0, 0, 0};
  logic [15:0] img [0:199];
  int          checks = 0;
  int          errors = 0;
  bit          done6;

  // Transaction monitor: samples on the falling edge, between active edges.
  always @(negedge clk) begin
    txn_t t;
    for (int d = 0; d < 4; d++) begin
      if (in_valid[d] && in_ready[d]) acc[d] = acc[d] + 1;
      if (win_valid[d] && win_ready[d]) begin
        t.d = d;
        t.data = win_data[d];
        t.last = win_last[d];
        q.push_back(t);
        $display("WIN dut%0d last=%0b data=%h", d, win_last[d], win_data[d]);
      end
    end
  end

  task automatic chk(input string name, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_win(input int base, input int w, input int r0, input int c0);
    logic [WW-1:0] m = '0;
    for (int wr = 0; wr < 5; wr++)
      for (int wc = 0; wc < 5; wc++)
        m[16*(wr*5+wc) +: 16] = img[base + (r0+wr)*w + c0 + wc];
    return m;
  endfunction

  task automatic send_pixels(input int d, input int first, input int n, input bit rnd);
    for (int i = first; i < first + n; i++) begin
      int guard = 0;
      bit done = 0;
      in_data[d] = img[i];
      while (!done) begin
        in_valid[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (in_valid[d] && in_ready[d]) done = 1;
        @(posedge clk); #1;
        guard++;
        if (!done && guard > 500) begin
          checks++;
          errors++;
          $display("FAIL send_timeout dut%0d got=stalled exp=accept pixel %0d", d, i);
          in_valid[d] = 1'b0;
          return;
        end
      end
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_count(input string name, input int qb, input int n);
    int g = 0;
    while (q.size() - qb < n && g < 400) begin
      @(posedge clk); #1;
      g++;
    end
    repeat (5) begin @(posedge clk); #1; end
    chk_int(name, q.size() - qb, n);
  endtask

  task automatic check_windows(input string tag, input int qi_in, input int base,
                               input int w, input int h, input int s, output int qi_out);
    int qi = qi_in;
    for (int r0 = 0; r0 + 5 <= h; r0 += s) begin
      for (int c0 = 0; c0 + 5 <= w; c0 += s) begin
        if (qi < q.size()) begin
          chk($sformatf("%s_win%0d_data", tag, qi - qi_in), q[qi].data, model_win(base, w, r0, c0));
          chk_int($sformatf("%s_win%0d_last", tag, qi - qi_in), q[qi].last,
                  (r0 + s + 5 > h) && (c0 + s + 5 > w));
        end else begin
          checks++;
          errors++;
          $display("FAIL %s_win%0d got=none exp=window", tag, qi - qi_in);
        end
        qi++;
      end
    end
    qi_out = qi;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tbl [9];
    logic [WW-1:0] exp_w;
    logic [WW-1:0] first;
    int            qb, qn, a0, g;

    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b0;
      in_data[d] = '0;
      win_ready[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk_int($sformatf("rst_valid%0d", d), win_valid[d], 0);
      chk_int($sformatf("rst_last%0d", d), win_last[d], 0);
      chk($sformatf("rst_data%0d", d), win_data[d], '0);
      chk_int($sformatf("rst_ready%0d", d), in_ready[d], 1);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // 5x5 stride 5: single window, latency one cycle from the 25th pixel.
    for (int i = 0; i < 25; i++) img[i] = (i == 20) ? 16'h4200 : 16'h4000;
    qb = q.size();
    send_pixels(0, 0, 24, 0);
    in_data[0] = img[24];
    in_valid[0] = 1'b1;
    @(negedge clk);
    chk_int("t1_ready_before", in_ready[0], 1);
    chk_int("t1_valid_before", win_valid[0], 0);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk_int("t1_valid_lat1", win_valid[0], 1);
    chk_int("t1_last", win_last[0], 1);
    exp_w = {25{16'h4000}};
    exp_w[335:320] = 16'h4200;
    chk("t1_data", win_data[0], exp_w);
    wait_count("t1_count", qb, 1);
    check_windows("t1", qb, 0, 5, 5, 5, qn);

    // 6x6 stride 1, pixel = row*16+col, hand-computed element table.
    for (int i = 0; i < 36; i++) img[i] = 16'((i / 6) * 16 + (i % 6));
    tbl[0] = '{0, 0, 0, 16'h0000, 1'b0};
    tbl[1] = '{0, 4, 4, 16'h0044, 1'b0};
    tbl[2] = '{1, 0, 0, 16'h0001, 1'b0};
    tbl[3] = '{1, 4, 4, 16'h0045, 1'b0};
    tbl[4] = '{2, 0, 0, 16'h0010, 1'b0};
    tbl[5] = '{2, 4, 0, 16'h0050, 1'b0};
    tbl[6] = '{3, 0, 0, 16'h0011, 1'b1};
    tbl[7] = '{3, 4, 4, 16'h0055, 1'b1};
    tbl[8] = '{3, 2, 3, 16'h0034, 1'b1};
    qb = q.size();
    a0 = acc[1];
    send_pixels(1, 0, 36, 0);
    wait_count("t2_count", qb, 4);
    chk_int("t2_accepted", acc[1] - a0, 36);
    for (int k = 0; k < 9; k++) begin
      if (qb + tbl[k].widx < q.size()) begin
        chk_int($sformatf("t2_w%0d_e%0d%0d", tbl[k].widx, tbl[k].wr, tbl[k].wc),
                q[qb + tbl[k].widx].data[16*(tbl[k].wr*5 + tbl[k].wc) +: 16], tbl[k].exp_elem);
        chk_int($sformatf("t2_w%0d_last", tbl[k].widx), q[qb + tbl[k].widx].last, tbl[k].exp_last);
      end else begin
        checks++;
        errors++;
        $display("FAIL t2_w%0d got=none exp=window", tbl[k].widx);
      end
    end

    // 10x10 stride 5 with downstream stalled for 10 cycles after the first window.
    for (int i = 0; i < 100; i++) img[i] = 16'(16'h3000 + i * 3);
    qb = q.size();
    a0 = acc[2];
    win_ready[2] = 1'b0;
    fork
      send_pixels(2, 0, 100, 0);
      begin
        first = model_win(0, 10, 0, 0);
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!win_valid[2] && g < 1000);
        for (int c = 0; c < 10; c++) begin
          chk_int($sformatf("t3_hold_valid_c%0d", c), win_valid[2], 1);
          chk_int($sformatf("t3_hold_ready_c%0d", c), in_ready[2], 0);
          chk($sformatf("t3_hold_data_c%0d", c), win_data[2], first);
          @(negedge clk);
        end
        @(posedge clk); #1;
        win_ready[2] = 1'b1;
      end
    join
    wait_count("t3_count", qb, 4);
    chk_int("t3_accepted", acc[2] - a0, 100);
    check_windows("t3", qb, 0, 10, 10, 5, qn);

    // Two back-to-back 5x5 frames with continuous valid/ready.
    for (int i = 0; i < 25; i++) begin
      img[i] = 16'(16'h1000 + i);
      img[25 + i] = 16'(16'h2000 + i);
    end
    qb = q.size();
    send_pixels(0, 0, 50, 0);
    wait_count("t4_count", qb, 2);
    check_windows("t4_f0", qb, 0, 5, 5, 5, qn);
    check_windows("t4_f1", qn, 25, 5, 5, 5, qn);

    // Async reset while a window is pending, then mid-frame at pixel 13.
    for (int i = 0; i < 25; i++) img[i] = 16'(16'h5000 + i);
    for (int i = 25; i < 38; i++) img[i] = 16'(16'hDEAD ^ i);
    for (int i = 50; i < 75; i++) img[i] = 16'(16'h6000 + i);
    win_ready[0] = 1'b0;
    send_pixels(0, 0, 25, 0);
    @(posedge clk); #1;
    chk_int("t5_pending", win_valid[0], 1);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk_int("t5_async_valid", win_valid[0], 0);
    chk_int("t5_async_last", win_last[0], 0);
    chk("t5_async_data", win_data[0], '0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_pixels(0, 25, 13, 0);
    #3;
    reset = 1'b1;
    #1;
    chk_int("t5_mid_valid", win_valid[0], 0);
    @(posedge clk); #1;
    reset = 1'b0;
    win_ready[0] = 1'b1;
    qb = q.size();
    send_pixels(0, 50, 25, 0);
    wait_count("t5_count", qb, 1);
    check_windows("t5", qb, 50, 5, 5, 5, qn);

    // 8x8 stride 1 with random valid/ready and special FP16 patterns.
    for (int i = 0; i < 64; i++) img[i] = 16'($urandom);
    img[0] = 16'h7E00;
    img[9] = 16'h8000;
    img[18] = 16'h7C00;
    img[36] = 16'hFC00;
    qb = q.size();
    a0 = acc[3];
    done6 = 1'b0;
    fork
      begin
        send_pixels(3, 0, 64, 1);
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          @(posedge clk); #1;
          win_ready[3] = 1'($urandom_range(0, 1));
        end
      end
    join
    win_ready[3] = 1'b1;
    wait_count("t6_count", qb, 16);
    chk_int("t6_accepted", acc[3] - a0, 64);
    check_windows("t6", qb, 0, 8, 8, 1, qn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
